// File: rtl/pipeline_ctrl_pkg.sv
// Shared types, constants and instruction field positions for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_LOAD_STALL = 3'd1,
        ST_MEM_WAIT   = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_HALTED     = 3'd4
    } hz_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int REG_W   = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef struct packed {
        logic pc_write;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
    } ctrl_t;

    localparam ctrl_t CTRL_PASS       = '{pc_write: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_FREEZE     = '{if_id_stall: 1'b1, id_ex_stall: 1'b1, ex_mem_stall: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_REDIRECT   = '{pc_write: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_LOAD_USE   = '{if_id_stall: 1'b1, id_ex_flush: 1'b1, default: 1'b0};
    // Fetch miss and NOP injection both hold the PC and bubble the IF/ID register.
    localparam ctrl_t CTRL_BUBBLE     = '{if_id_flush: 1'b1, default: 1'b0};

    function automatic logic [REG_W-1:0] reg_field(input logic [31:0] instr, input int lsb);
        return instr[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: count is registered (one cycle after inc), clear wins over increment.
// No backpressure; it sticks at all-ones until cleared or reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard/halt controller: stall, flush and PC-write controls are combinational
// from registered state plus current inputs (zero latency); counters and mem_timeout are registered.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16,
    parameter int DRAIN_CYCLES   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_id_instr,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    input  logic             halt_req,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             halt_ack,
    output logic [2:0]       hazard_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TMO_MAX = TO_W'(TIMEOUT_CYCLES);

    hz_state_e       state_q, state_d;
    logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            mem_timeout_q, mem_timeout_d;
    ctrl_t           ctrl;
    logic            flush_evt;
    logic            stall_inc;
    logic            load_use;
    logic [4:0]      rs1, rs2;
    logic            unused_instr_bits;

    assign rs1 = reg_field(if_id_instr, RS1_LSB);
    assign rs2 = reg_field(if_id_instr, RS2_LSB);
    assign unused_instr_bits = ^{if_id_instr[31:25], if_id_instr[14:0]};

    assign load_use = id_ex_mem_read && (id_ex_rd != '0) && ((id_ex_rd == rs1) || (id_ex_rd == rs2));

    always_comb begin
        ctrl        = CTRL_PASS;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        flush_evt   = 1'b0;
        case (state_q)
            ST_RUN, ST_LOAD_STALL, ST_MEM_WAIT: begin
                state_d = ST_RUN;
                if (dmem_busy) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = ST_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    ctrl      = CTRL_REDIRECT;
                    flush_evt = 1'b1;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                    // Leaving MEM_WAIT always lands in RUN; the stall itself still happens this cycle.
                    if (state_q != ST_MEM_WAIT) state_d = ST_LOAD_STALL;
                end else if (!imem_ready) begin
                    ctrl = CTRL_BUBBLE;
                end else if (halt_req && (state_q == ST_RUN)) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DC_W'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                ctrl = CTRL_BUBBLE;
                if (dmem_busy) begin
                    ctrl = CTRL_FREEZE;
                end else if (ex_branch_taken) begin
                    ctrl        = CTRL_REDIRECT;
                    flush_evt   = 1'b1;
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
                if (!halt_req) begin
                    state_d     = dmem_busy ? ST_MEM_WAIT : ST_RUN;
                    drain_cnt_d = '0;
                end else if (drain_cnt_d == '0) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                ctrl = CTRL_BUBBLE;
                if (!halt_req) state_d = ST_RUN;
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = '0;
            end
        endcase
    end

    assign stall_inc = !ctrl.pc_write &&
                       ((state_q == ST_RUN) || (state_q == ST_LOAD_STALL) || (state_q == ST_MEM_WAIT));

    always_comb begin
        tmo_cnt_d = '0;
        if (dmem_busy) tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        mem_timeout_d = mem_timeout_q || (tmo_cnt_d == TMO_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            drain_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .clr_i (perf_clr),
        .cnt_o (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_evt),
        .clr_i (perf_clr),
        .cnt_o (flush_count)
    );

    // Reset forces every control low, including pc_write, regardless of inputs.
    assign {pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall} = rst ? 6'b0 : ctrl;
    assign halt_ack     = !rst && (state_q == ST_HALTED);
    assign hazard_state = state_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus a randomized run against a rule-level model.
module tb_pipeline_hazard_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    // Control vector order: pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall
    localparam logic [5:0] C_PASS = 6'b100000;
    localparam logic [5:0] C_FRZ  = 6'b010101;
    localparam logic [5:0] C_RED  = 6'b101010;
    localparam logic [5:0] C_LU   = 6'b010010;
    localparam logic [5:0] C_BUB  = 6'b001000;
    localparam int M_RUN = 0, M_LS = 1, M_MW = 2, M_DR = 3, M_HA = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_id_instr;
    logic [4:0]  id_ex_rd;
    logic        id_ex_mem_read, ex_branch_taken, imem_ready, dmem_busy, halt_req, perf_clr;
    logic        pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic        halt_ack, mem_timeout;
    logic [2:0]  hazard_state;
    logic [15:0] stall_cycles, flush_count;
    logic [5:0]  ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(256), .CNT_W(16), .DRAIN_CYCLES(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_id_instr     (if_id_instr),
        .id_ex_rd        (id_ex_rd),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .dmem_busy       (dmem_busy),
        .halt_req        (halt_req),
        .perf_clr        (perf_clr),
        .pc_write        (pc_write),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_stall    (ex_mem_stall),
        .halt_ack        (halt_ack),
        .hazard_state    (hazard_state),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_timeout     (mem_timeout)
    );

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        if_id_instr     = NOP;
        id_ex_rd        = 5'd0;
        id_ex_mem_read  = 1'b0;
        ex_branch_taken = 1'b0;
        imem_ready      = 1'b1;
        dmem_busy       = 1'b0;
        halt_req        = 1'b0;
        perf_clr        = 1'b0;
    endtask

    task automatic clear_perf();
        next(); idle(); perf_clr = 1'b1;
        next(); perf_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        ex_branch_taken = 1'b1;
        halt_req = 1'b1;
        repeat (2) next();
        settle();
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL rst_ctl got %b want %b", ctl, 6'b0); end
        checks++; if (hazard_state !== 3'd0 || halt_ack !== 1'b0) begin errors++; $display("FAIL rst_state got %0d/%b want 0/0", hazard_state, halt_ack); end
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL rst_cnt got %0d/%0d/%b want 0/0/0", stall_cycles, flush_count, mem_timeout); end
        next(); idle(); rst = 1'b0;
        settle();
        checks++; if (ctl !== C_PASS) begin errors++; $display("FAIL post_rst_ctl got %b want %b", ctl, C_PASS); end
    endtask

    task automatic test_load_use();
        clear_perf();
        next(); id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_instr = 32'h0050_0033;
        settle();
        checks++; if (ctl !== C_LU || hazard_state !== 3'd0) begin errors++; $display("FAIL lu_ctl got %b/%0d want %b/0", ctl, hazard_state, C_LU); end
        next(); idle();
        settle();
        checks++; if (hazard_state !== 3'd1 || ctl !== C_PASS) begin errors++; $display("FAIL lu_state got %0d/%b want 1/%b", hazard_state, ctl, C_PASS); end
        checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_stall got %0d want 1", stall_cycles); end
        next(); id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; if_id_instr = NOP;
        settle();
        checks++; if (ctl !== C_PASS) begin errors++; $display("FAIL lu_x0 got %b want %b", ctl, C_PASS); end
        next(); id_ex_mem_read = 1'b1; id_ex_rd = 5'd9; if_id_instr = 32'h0004_8013;
        settle();
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1 got %b want %b", ctl, C_LU); end
        next(); idle(); id_ex_rd = 5'd9; if_id_instr = 32'h0004_8013;
        settle();
        checks++; if (ctl !== C_PASS || hazard_state !== 3'd1) begin errors++; $display("FAIL lu_noload got %b/%0d want %b/1", ctl, hazard_state, C_PASS); end
    endtask

    task automatic test_branch_vs_load();
        clear_perf();
        next(); id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_instr = 32'h0050_0033; ex_branch_taken = 1'b1;
        settle();
        checks++; if (ctl !== C_RED) begin errors++; $display("FAIL br_lu_ctl got %b want %b", ctl, C_RED); end
        next(); idle();
        settle();
        checks++; if (flush_count !== 16'd1 || stall_cycles !== 16'd0 || hazard_state !== 3'd0) begin errors++; $display("FAIL br_lu_cnt got %0d/%0d/%0d want 1/0/0", flush_count, stall_cycles, hazard_state); end
    endtask

    task automatic test_perf_clr();
        clear_perf();
        next(); imem_ready = 1'b0;
        settle();
        checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL imiss_ctl got %b want %b", ctl, C_BUB); end
        next(); next();
        settle();
        checks++; if (stall_cycles !== 16'd2) begin errors++; $display("FAIL imiss_stall got %0d want 2", stall_cycles); end
        next(); perf_clr = 1'b1;
        next(); idle();
        settle();
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL clr_vs_stall got %0d want 0", stall_cycles); end
        next(); ex_branch_taken = 1'b1; perf_clr = 1'b1;
        next(); idle();
        settle();
        checks++; if (flush_count !== 16'd0) begin errors++; $display("FAIL clr_vs_flush got %0d want 0", flush_count); end
    endtask

    task automatic test_mem_wait_branch();
        clear_perf();
        for (int i = 0; i < 4; i++) begin
            next(); dmem_busy = 1'b1; ex_branch_taken = 1'b1;
            settle();
            checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL mw_freeze%0d got %b want %b", i, ctl, C_FRZ); end
        end
        next(); dmem_busy = 1'b0; ex_branch_taken = 1'b1;
        settle();
        checks++; if (ctl !== C_RED || hazard_state !== 3'd2) begin errors++; $display("FAIL mw_exit got %b/%0d want %b/2", ctl, hazard_state, C_RED); end
        next(); idle();
        settle();
        checks++; if (stall_cycles !== 16'd4 || flush_count !== 16'd1 || hazard_state !== 3'd0) begin errors++; $display("FAIL mw_cnt got %0d/%0d/%0d want 4/1/0", stall_cycles, flush_count, hazard_state); end
    endtask

    task automatic test_halt();
        clear_perf();
        next(); halt_req = 1'b1;
        settle();
        checks++; if (ctl !== C_PASS || hazard_state !== 3'd0) begin errors++; $display("FAIL halt_req_cycle got %b/%0d want %b/0", ctl, hazard_state, C_PASS); end
        for (int k = 1; k <= 3; k++) begin
            next();
            settle();
            checks++; if (hazard_state !== 3'd3 || ctl !== C_BUB || halt_ack !== 1'b0) begin errors++; $display("FAIL drain%0d got %0d/%b/%b want 3/%b/0", k, hazard_state, ctl, halt_ack, C_BUB); end
        end
        for (int k = 4; k <= 5; k++) begin
            next();
            settle();
            checks++; if (hazard_state !== 3'd4 || ctl !== C_BUB || halt_ack !== 1'b1) begin errors++; $display("FAIL halted%0d got %0d/%b/%b want 4/%b/1", k, hazard_state, ctl, halt_ack, C_BUB); end
        end
        next(); halt_req = 1'b0;
        settle();
        checks++; if (halt_ack !== 1'b1) begin errors++; $display("FAIL release_ack got %b want 1", halt_ack); end
        next();
        settle();
        checks++; if (hazard_state !== 3'd0 || halt_ack !== 1'b0 || ctl !== C_PASS) begin errors++; $display("FAIL resume got %0d/%b/%b want 0/0/%b", hazard_state, halt_ack, ctl, C_PASS); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL halt_nostall got %0d want 0", stall_cycles); end
    endtask

    task automatic test_reset_mid_drain();
        next(); halt_req = 1'b1;
        next(); next();
        settle();
        checks++; if (hazard_state !== 3'd3) begin errors++; $display("FAIL pre_abort got %0d want 3", hazard_state); end
        rst = 1'b1;
        #1;
        checks++; if (ctl !== 6'b0 || hazard_state !== 3'd0 || halt_ack !== 1'b0) begin errors++; $display("FAIL abort got %b/%0d/%b want 0/0/0", ctl, hazard_state, halt_ack); end
        for (int k = 0; k < 3; k++) begin
            next();
            settle();
            checks++; if (halt_ack !== 1'b0 || ctl !== 6'b0) begin errors++; $display("FAIL abort_hold%0d got %b/%b want 0/0", k, halt_ack, ctl); end
        end
        next(); idle(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            checks++; if (hazard_state !== 3'd0 || halt_ack !== 1'b0 || ctl !== C_PASS) begin errors++; $display("FAIL after_abort%0d got %0d/%b/%b want 0/0/%b", k, hazard_state, halt_ack, ctl, C_PASS); end
            next();
        end
    endtask

    task automatic test_random();
        int mode, drain, stall, flush, busy_run;
        bit mto, hold_halt;
        mode = M_RUN; drain = 0; stall = 0; flush = 0; busy_run = 0; mto = 0; hold_halt = 0;
        for (int c = 0; c < 1500; c++) begin
            int rs1, rs2, nmode;
            bit lu, eack, finc;
            logic [5:0] ectl;
            next();
            if ($urandom_range(11) == 0) hold_halt = !hold_halt;
            halt_req        = hold_halt;
            dmem_busy       = ($urandom_range(5) == 0);
            ex_branch_taken = ($urandom_range(5) == 0);
            imem_ready      = ($urandom_range(5) != 0);
            id_ex_mem_read  = ($urandom_range(2) == 0);
            id_ex_rd        = 5'($urandom_range(7));
            if_id_instr     = $urandom;
            if_id_instr[19:15] = 5'($urandom_range(7));
            if_id_instr[24:20] = 5'($urandom_range(7));
            perf_clr        = ($urandom_range(39) == 0);
            // Keep the stream to situations a real pipeline can produce after a stall/halt.
            if (mode != M_RUN) id_ex_mem_read = 1'b0;
            if (mode == M_DR || mode == M_HA) ex_branch_taken = 1'b0;
            if (mode == M_HA || (mode == M_DR && !halt_req)) dmem_busy = 1'b0;
            settle();
            rs1 = (if_id_instr >> 15) % 32;
            rs2 = (if_id_instr >> 20) % 32;
            lu = id_ex_mem_read && id_ex_rd != 0 && (id_ex_rd == rs1 || id_ex_rd == rs2);
            eack = 0; finc = 0; nmode = mode; ectl = C_PASS;
            if (mode == M_DR) begin
                if (dmem_busy) ectl = C_FRZ;
                else begin
                    ectl = C_BUB;
                    if (!halt_req) begin nmode = M_RUN; drain = 0; end
                    else begin drain = drain - 1; if (drain == 0) nmode = M_HA; end
                end
            end else if (mode == M_HA) begin
                ectl = C_BUB; eack = 1;
                if (!halt_req) nmode = M_RUN;
            end else begin
                nmode = M_RUN;
                if (dmem_busy) begin ectl = C_FRZ; nmode = M_MW; end
                else if (ex_branch_taken) begin ectl = C_RED; finc = 1; end
                else if (lu) begin ectl = C_LU; nmode = M_LS; end
                else if (!imem_ready) ectl = C_BUB;
                else if (halt_req && mode == M_RUN) begin nmode = M_DR; drain = 3; end
            end
            checks++; if (ctl !== ectl) begin errors++; $display("FAIL rnd_ctl c%0d got %b want %b", c, ctl, ectl); end
            checks++; if (hazard_state !== 3'(mode) || halt_ack !== eack) begin errors++; $display("FAIL rnd_state c%0d got %0d/%b want %0d/%b", c, hazard_state, halt_ack, mode, eack); end
            checks++; if (stall_cycles !== 16'(stall) || flush_count !== 16'(flush) || mem_timeout !== mto) begin errors++; $display("FAIL rnd_cnt c%0d got %0d/%0d/%b want %0d/%0d/%b", c, stall_cycles, flush_count, mem_timeout, stall, flush, mto); end
            if (perf_clr) begin stall = 0; flush = 0; end
            else begin
                if (mode <= M_MW && ectl[5] == 1'b0 && stall < 65535) stall++;
                if (finc && flush < 65535) flush++;
            end
            busy_run = dmem_busy ? busy_run + 1 : 0;
            if (busy_run >= 256) mto = 1;
            mode = nmode;
        end
        next(); idle();
        repeat (6) next();
    endtask

    task automatic test_timeout_sat();
        clear_perf();
        next(); dmem_busy = 1'b1;
        repeat (255) next();
        settle();
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL tmo_255 got %b want 0", mem_timeout); end
        next();
        settle();
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL tmo_256 got %b want 1", mem_timeout); end
        repeat (65534 - 256) next();
        settle();
        checks++; if (stall_cycles !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", stall_cycles); end
        repeat (10) next();
        settle();
        checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", stall_cycles); end
        next(); dmem_busy = 1'b0;
        next();
        settle();
        checks++; if (mem_timeout !== 1'b1 || stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL tmo_sticky got %b/%h want 1/ffff", mem_timeout, stall_cycles); end
        rst = 1'b1;
        #1;
        checks++; if (mem_timeout !== 1'b0 || stall_cycles !== 16'd0) begin errors++; $display("FAIL tmo_rst got %b/%h want 0/0", mem_timeout, stall_cycles); end
        next(); rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_load();
        test_perf_clr();
        test_mem_wait_branch();
        test_halt();
        test_reset_mid_drain();
        test_random();
        test_timeout_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
